// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET, updates the trap CSRs
// and hands the datapath a redirect target that is held until acknowledged.
module trap_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_timer,
  input  logic            irq_sw,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] mie_csr,
  input  logic [XLEN-1:0] mtvec,
  input  logic            instr_boundary,
  input  logic [XLEN-1:0] cur_pc,
  input  logic [XLEN-1:0] next_pc,
  input  logic            mret,
  input  logic            csr_mstatus_we,
  input  logic            csr_mepc_we,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            redirect_ack,
  output logic            busy,
  output logic            trap_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic [XLEN-1:0] mip,
  output logic            mstatus_mie,
  output logic            mstatus_mpie
);

  typedef enum logic [1:0] {StIdle, StSave, StRedirect, StRet} state_e;

  state_e          state;
  logic            pend_sw, pend_timer, pend_ext;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] mip_next;
  logic            unused_bits;

  always_comb begin
    pend_sw    = mip[3] & mie_csr[3];
    pend_timer = mip[7] & mie_csr[7];
    pend_ext   = mip[11] & mie_csr[11];
    irq_take   = instr_boundary & mstatus_mie & (pend_sw | pend_timer | pend_ext);
    if (pend_ext) begin
      irq_code = 4'd11;
    end else if (pend_sw) begin
      irq_code = 4'd3;
    end else begin
      irq_code = 4'd7;
    end
    vec_base     = {mtvec[XLEN-1:2], 2'b00};
    mip_next     = '0;
    mip_next[3]  = irq_sw;
    mip_next[7]  = irq_timer;
    mip_next[11] = irq_ext;
  end

  assign unused_bits = ^{cur_pc[1:0], csr_wdata[1:0], mie_csr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      busy          <= 1'b0;
      trap_redirect <= 1'b0;
      redirect_pc   <= '0;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
      mip           <= '0;
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
    end else begin
      mip <= mip_next;
      unique case (state)
        StIdle: begin
          // Trap/MRET acceptance takes priority over a same-cycle CSR write.
          if (exc_req) begin
            mcause <= XLEN'(exc_cause);
            mepc   <= {cur_pc[XLEN-1:2], 2'b00};
            mtval  <= exc_tval;
            state  <= StSave;
            busy   <= 1'b1;
          end else if (irq_take) begin
            mcause <= (XLEN'(1) << (XLEN - 1)) | XLEN'(irq_code);
            mepc   <= next_pc;
            mtval  <= '0;
            state  <= StSave;
            busy   <= 1'b1;
          end else if (mret) begin
            state <= StRet;
            busy  <= 1'b1;
          end else begin
            if (csr_mstatus_we) begin
              mstatus_mie  <= csr_wdata[3];
              mstatus_mpie <= csr_wdata[7];
            end
            if (csr_mepc_we) begin
              mepc <= {csr_wdata[XLEN-1:2], 2'b00};
            end
          end
        end
        StSave: begin
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
          // Only interrupts are vectored; the add wraps at XLEN bits.
          if (mtvec[1:0] == 2'b01 && mcause[XLEN-1]) begin
            redirect_pc <= vec_base + {mcause[XLEN-3:0], 2'b00};
          end else begin
            redirect_pc <= vec_base;
          end
          state         <= StRedirect;
          trap_redirect <= 1'b1;
        end
        StRet: begin
          mstatus_mie   <= mstatus_mpie;
          mstatus_mpie  <= 1'b1;
          redirect_pc   <= mepc;
          state         <= StRedirect;
          trap_redirect <= 1'b1;
        end
        StRedirect: begin
          if (redirect_ack) begin
            state         <= StIdle;
            busy          <= 1'b0;
            trap_redirect <= 1'b0;
          end
        end
        default: begin
          state         <= StIdle;
          busy          <= 1'b0;
          trap_redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_req = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] exc_tval = '0;
  logic        irq_timer = 1'b0, irq_sw = 1'b0, irq_ext = 1'b0;
  logic [31:0] mie_csr = '0;
  logic [31:0] mtvec = 32'h1000;
  logic        instr_boundary = 1'b0;
  logic [31:0] cur_pc = '0, next_pc = '0;
  logic        mret = 1'b0;
  logic        csr_mstatus_we = 1'b0, csr_mepc_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic        redirect_ack = 1'b0;
  logic        busy, trap_redirect, mstatus_mie, mstatus_mpie;
  logic [31:0] redirect_pc, mepc, mcause, mtval, mip;

  int n_tests = 0;
  int n_fail  = 0;

  trap_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .irq_timer(irq_timer), .irq_sw(irq_sw), .irq_ext(irq_ext), .mie_csr(mie_csr),
    .mtvec(mtvec), .instr_boundary(instr_boundary), .cur_pc(cur_pc), .next_pc(next_pc),
    .mret(mret), .csr_mstatus_we(csr_mstatus_we), .csr_mepc_we(csr_mepc_we),
    .csr_wdata(csr_wdata), .redirect_ack(redirect_ack), .busy(busy),
    .trap_redirect(trap_redirect), .redirect_pc(redirect_pc), .mepc(mepc), .mcause(mcause),
    .mtval(mtval), .mip(mip), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is either idle, preparing (one cycle) or redirecting until acked.
  logic        m_busy, m_ret, m_redir, m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mip, m_rpc;
  logic        m_take_irq;
  logic [3:0]  m_code;

  always_comb begin
    m_take_irq = 1'b0;
    m_code     = 4'd0;
    if (m_mie && instr_boundary) begin
      if (m_mip[11] && mie_csr[11]) begin
        m_take_irq = 1'b1; m_code = 4'd11;
      end else if (m_mip[3] && mie_csr[3]) begin
        m_take_irq = 1'b1; m_code = 4'd3;
      end else if (m_mip[7] && mie_csr[7]) begin
        m_take_irq = 1'b1; m_code = 4'd7;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_ret <= 0; m_redir <= 0; m_mie <= 0; m_mpie <= 0;
      m_mepc <= 0; m_mcause <= 0; m_mtval <= 0; m_mip <= 0; m_rpc <= 0;
    end else begin
      if (!m_busy) begin
        if (exc_req) begin
          m_mcause <= {28'd0, exc_cause};
          m_mepc   <= cur_pc & ~32'h3;
          m_mtval  <= exc_tval;
          m_busy <= 1; m_ret <= 0;
        end else if (m_take_irq) begin
          m_mcause <= 32'h8000_0000 | {28'd0, m_code};
          m_mepc   <= next_pc;
          m_mtval  <= 0;
          m_busy <= 1; m_ret <= 0;
        end else if (mret) begin
          m_busy <= 1; m_ret <= 1;
        end else begin
          if (csr_mstatus_we) begin
            m_mie  <= csr_wdata[3];
            m_mpie <= csr_wdata[7];
          end
          if (csr_mepc_we) m_mepc <= csr_wdata & ~32'h3;
        end
      end else if (!m_redir) begin
        if (m_ret) begin
          m_mie <= m_mpie; m_mpie <= 1; m_rpc <= m_mepc;
        end else begin
          m_mpie <= m_mie; m_mie <= 0;
          if (mtvec[1:0] == 2'b01 && m_mcause[31])
            m_rpc <= (mtvec & ~32'h3) + 32'd4 * {1'b0, m_mcause[30:0]};
          else
            m_rpc <= mtvec & ~32'h3;
        end
        m_redir <= 1;
      end else if (redirect_ack) begin
        m_busy <= 0; m_redir <= 0;
      end
      m_mip <= {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("trap_redirect", 32'(trap_redirect), 32'(m_busy && m_redir));
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("mepc", mepc, m_mepc);
      chk("mcause", mcause, m_mcause);
      chk("mtval", mtval, m_mtval);
      chk("mip", mip, m_mip);
      chk("mstatus_mie", 32'(mstatus_mie), 32'(m_mie));
      chk("mstatus_mpie", 32'(mstatus_mpie), 32'(m_mpie));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_mstatus(input logic [31:0] d);
    csr_mstatus_we = 1; csr_wdata = d;
    cyc();
    csr_mstatus_we = 0;
  endtask

  task automatic ack();
    redirect_ack = 1;
    cyc();
    redirect_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_redirect", 32'(trap_redirect), 0);
    chk("rst_mepc", mepc, 0);
    cyc();
    reset = 0;
    cyc();

    // Exception with direct vector.
    set_mstatus(32'h8);
    exc_req = 1; exc_cause = 4; cur_pc = 32'h104; exc_tval = 32'h203;
    cyc();
    exc_req = 0;
    chk("exc_busy", 32'(busy), 1);
    chk("exc_redirect_early", 32'(trap_redirect), 0);
    chk("exc_mcause", mcause, 32'h4);
    chk("exc_mepc", mepc, 32'h104);
    chk("exc_mtval", mtval, 32'h203);
    cyc();
    chk("exc_redirect", 32'(trap_redirect), 1);
    chk("exc_rpc", redirect_pc, 32'h1000);
    chk("exc_mie", 32'(mstatus_mie), 0);
    chk("exc_mpie", 32'(mstatus_mpie), 1);
    ack();
    chk("exc_busy_done", 32'(busy), 0);

    // Interrupt priority with vectored mtvec.
    mtvec = 32'h1001; mie_csr = 32'h880; next_pc = 32'h40;
    irq_timer = 1; irq_ext = 1; instr_boundary = 1;
    set_mstatus(32'h8);
    cyc();
    irq_timer = 0; irq_ext = 0; instr_boundary = 0;
    chk("irq_mcause", mcause, 32'h8000_000B);
    chk("irq_mepc", mepc, 32'h40);
    chk("irq_mtval", mtval, 32'h0);
    cyc();
    chk("irq_rpc", redirect_pc, 32'h102C);
    ack();
    cyc();

    // Exception and MRET together: exception wins, MRET dropped.
    set_mstatus(32'h8);
    exc_req = 1; mret = 1; exc_cause = 5; cur_pc = 32'h203; exc_tval = 32'h77;
    cyc();
    exc_req = 0; mret = 0;
    chk("em_mcause", mcause, 32'h5);
    chk("em_mepc", mepc, 32'h200);
    cyc();
    chk("em_rpc", redirect_pc, 32'h1000);
    chk("em_mie", 32'(mstatus_mie), 0);
    ack();
    mret = 1;
    cyc();
    mret = 0;
    chk("ret_busy", 32'(busy), 1);
    cyc();
    chk("ret_redirect", 32'(trap_redirect), 1);
    chk("ret_rpc", redirect_pc, 32'h200);
    chk("ret_mie", 32'(mstatus_mie), 1);
    chk("ret_mpie", 32'(mstatus_mpie), 1);
    ack();

    // Long ack wait with ignored requests.
    exc_req = 1; exc_cause = 0; cur_pc = 32'h300; exc_tval = 32'h301;
    cyc();
    exc_req = 0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      exc_req = i[0]; mret = i[1]; irq_ext = i[0]; instr_boundary = 1;
      exc_cause = 4; cur_pc = 32'h999;
      cyc();
      chk("wait_redirect", 32'(trap_redirect), 1);
      chk("wait_rpc", redirect_pc, 32'h1000);
    end
    exc_req = 0; mret = 0; irq_ext = 0; instr_boundary = 0;
    chk("wait_mepc", mepc, 32'h300);
    ack();
    chk("wait_busy_done", 32'(busy), 0);
    cyc();

    // Asynchronous reset during REDIRECT.
    exc_req = 1; exc_cause = 4; cur_pc = 32'h500; exc_tval = 32'h5;
    cyc();
    exc_req = 0;
    cyc();
    reset = 1;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_redirect", 32'(trap_redirect), 0);
    chk("ar_rpc", redirect_pc, 0);
    chk("ar_mepc", mepc, 0);
    chk("ar_mcause", mcause, 0);
    chk("ar_mpie", 32'(mstatus_mpie), 0);
    cyc();
    reset = 0;
    cyc();
    chk("ar_idle", 32'(busy), 0);

    // Interrupt masked by mstatus.mie, then enabled by CSR write; vector add wraps.
    mtvec = 32'hFFFF_FFF1; mie_csr = 32'h80; irq_timer = 1; instr_boundary = 1;
    next_pc = 32'h80;
    cyc();
    cyc();
    chk("mask_mip", mip, 32'h80);
    chk("mask_busy", 32'(busy), 0);
    set_mstatus(32'h8);
    chk("en_busy", 32'(busy), 0);
    cyc();
    irq_timer = 0; instr_boundary = 0;
    chk("en_busy_taken", 32'(busy), 1);
    chk("en_mcause", mcause, 32'h8000_0007);
    chk("en_mepc", mepc, 32'h80);
    cyc();
    chk("wrap_rpc", redirect_pc, 32'h0000_000C);
    ack();

    // mepc CSR write, then trap overriding a same-cycle write.
    csr_mepc_we = 1; csr_wdata = 32'h1234_5677;
    cyc();
    chk("csr_mepc", mepc, 32'h1234_5674);
    csr_wdata = 32'hAAAA; exc_req = 1; exc_cause = 4; cur_pc = 32'h600;
    cyc();
    csr_mepc_we = 0; exc_req = 0;
    chk("ovr_mepc", mepc, 32'h600);
    cyc();
    chk("ovr_rpc", redirect_pc, 32'hFFFF_FFF0);
    ack();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
